rfs_wifi_cpu_div_cell: RTL and testbench

Iterative 32-bit integer divider: the inverse-direction companion to the CPU's hard multiplier cell. It sits beside the multiplier in the Nios II E/M datapath and takes the same E-stage operands (`E_src1` dividend, `E_src2` divisor). It produces quotient and remainder after a fixed multi-cycle latency, under a start/busy/done handshake. Radix-2 restoring algorithm with signed and unsigned modes and a pipeline-flush kill.

---
 rtl/rfs_wifi_cpu_div_pkg.sv | 21 ++
 rtl/rfs_wifi_cpu_div_step.sv | 25 ++
 rtl/rfs_wifi_cpu_div_cell.sv | 121 ++++++++++++
 tb/tb_rfs_wifi_cpu_div_cell.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfs_wifi_cpu_div_pkg.sv
// Shared types and constants for the iterative radix-2 divider cell.
// The divider sits beside the CPU's hard multiplier cell.
package rfs_wifi_cpu_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;
    localparam logic [DIV_WIDTH-1:0] DIV_OVF_QUOT  = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    function automatic int div_cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/rfs_wifi_cpu_div_step.sv
// One restoring-division step: shift {rem, quot} left, then a trial subtract.
// The subtract is kept in its own module so it can be duplicated for radix-4.
module rfs_wifi_cpu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Because rem < divisor on entry, the trial result fits in W+1 bits.
    // Its top bit is therefore a reliable sign bit.
    always_comb begin
        shifted   = {rem, quot[WIDTH-1]};
        trial     = shifted - {1'b0, divisor};
        rem_next  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quot_next = {quot[WIDTH-2:0], ~trial[WIDTH]};
    end

endmodule

// File: rtl/rfs_wifi_cpu_div_cell.sv
// Iterative 32-bit signed/unsigned divider under a start/busy/done handshake.
// Latency is fixed at WIDTH+2 cycles from start acceptance to the done pulse.
module rfs_wifi_cpu_div_cell
    import rfs_wifi_cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] E_src1,
    input  logic [WIDTH-1:0] E_src2,
    input  logic             E_div_start,
    input  logic             E_div_signed,
    input  logic             E_div_kill,
    output logic             M_div_busy,
    output logic             M_div_done,
    output logic [WIDTH-1:0] M_div_quot,
    output logic [WIDTH-1:0] M_div_rem
);

    localparam int CNT_W = div_cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] ZERO_QUOT = '1;
    localparam logic [WIDTH-1:0] OVF_QUOT  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q, quot_q, divisor_q, dividend_q;
    logic             quot_neg, rem_neg, div_zero, sgn_ovf;
    logic [WIDTH-1:0] rem_step, quot_step;
    logic [WIDTH-1:0] quot_fix, rem_fix;
    logic             accept, src1_neg, src2_neg, last_step;

    assign accept    = (state == IDLE) && E_div_start && !E_div_kill;
    assign src1_neg  = E_div_signed && E_src1[WIDTH-1];
    assign src2_neg  = E_div_signed && E_src2[WIDTH-1];
    assign last_step = (cnt == CNT_W'(WIDTH-1));

    rfs_wifi_cpu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem       (rem_q),
        .quot      (quot_q),
        .divisor   (divisor_q),
        .rem_next  (rem_step),
        .quot_next (quot_step)
    );

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        M_div_busy = (state != IDLE);
        M_div_done = (state == DONE);
        if (E_div_kill) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (E_div_start) state_next = CALC;
                CALC:    if (last_step)   state_next = FIX;
                FIX:     state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Sign correction first, then the zero-divisor and overflow overrides, in that priority.
    always_comb begin
        quot_fix = quot_neg ? -quot_q : quot_q;
        rem_fix  = rem_neg  ? -rem_q  : rem_q;
        if (div_zero) begin
            quot_fix = ZERO_QUOT;
            rem_fix  = dividend_q;
        end else if (sgn_ovf) begin
            quot_fix = OVF_QUOT;
            rem_fix  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: the working registers are reset along with the outputs; they are few and cheap to clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt        <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            quot_neg   <= 1'b0;
            rem_neg    <= 1'b0;
            div_zero   <= 1'b0;
            sgn_ovf    <= 1'b0;
            M_div_quot <= '0;
            M_div_rem  <= '0;
        end else begin
            if (accept) begin
                cnt        <= '0;
                rem_q      <= '0;
                quot_q     <= src1_neg ? -E_src1 : E_src1;
                divisor_q  <= src2_neg ? -E_src2 : E_src2;
                dividend_q <= E_src1;
                quot_neg   <= src1_neg ^ src2_neg;
                rem_neg    <= src1_neg;
                div_zero   <= (E_src2 == '0);
                sgn_ovf    <= E_div_signed && (E_src1 == OVF_QUOT) && (&E_src2);
            end
            if (state == CALC) begin
                cnt    <= cnt + CNT_W'(1);
                rem_q  <= rem_step;
                quot_q <= quot_step;
            end
            if (state == FIX && !E_div_kill) begin
                M_div_quot <= quot_fix;
                M_div_rem  <= rem_fix;
            end
        end
    end

endmodule

// File: tb/tb_rfs_wifi_cpu_div_cell.sv
// Self-checking bench for rfs_wifi_cpu_div_cell: scoreboard of expected results,
// one task per scenario, cycle-exact latency checks against a free-running cycle count.
module tb_rfs_wifi_cpu_div_cell;
    import rfs_wifi_cpu_div_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  E_src1, E_src2;
    logic          E_div_start, E_div_signed, E_div_kill;
    logic          M_div_busy, M_div_done;
    logic [W-1:0]  M_div_quot, M_div_rem;

    rfs_wifi_cpu_div_cell #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .E_src1       (E_src1),
        .E_src2       (E_src2),
        .E_div_start  (E_div_start),
        .E_div_signed (E_div_signed),
        .E_div_kill   (E_div_kill),
        .M_div_busy   (M_div_busy),
        .M_div_done   (M_div_done),
        .M_div_quot   (M_div_quot),
        .M_div_rem    (M_div_rem)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] last_q   = '0;
    logic [W-1:0] last_r   = '0;

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        int sa, sb_i;
        sa   = a;
        sb_i = b;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
        end else if (sgn) begin
            q = sa / sb_i;
            r = sa % sb_i;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Drives a start in the current cycle (cycle 0); returns at cycle 1 + #1.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                            input logic [W-1:0] eq, input logic [W-1:0] er, output int t0);
        exp_t e;
        E_src1       = a;
        E_src2       = b;
        E_div_signed = sgn;
        E_div_start  = 1'b1;
        t0           = cyc;
        e.q          = eq;
        e.r          = er;
        sb.push_back(e);
        @(negedge clk);
        n_checks++;
        if (M_div_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_idle: busy=%b required 0 (cycle %0d)", M_div_busy, cyc);
        end
        @(posedge clk);
        #1;
        E_div_start  = 1'b0;
        E_src1       = $urandom;
        E_src2       = $urandom;
        E_div_signed = 1'($urandom);
    endtask

    // Waits (bounded) for the done pulse, then checks latency and scoreboard entry.
    task automatic wait_done(input int t0, input string name);
        exp_t e;
        bit   seen = 1'b0;
        for (int k = 0; k < LAT + 8 && !seen; k++) begin
            @(negedge clk);
            if (M_div_done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, LAT + 8);
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end
        n_checks++;
        if ((cyc - t0) !== LAT) begin
            n_fail++;
            $display("FAIL %s_latency: done in cycle %0d required %0d", name, cyc - t0, LAT);
        end
        n_checks++;
        if (M_div_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy_at_done: busy=%b required 1", name, M_div_busy);
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_scoreboard: done with no expected result queued", name);
            return;
        end
        e = sb.pop_front();
        n_checks++;
        if (M_div_quot !== e.q) begin
            n_fail++;
            $display("FAIL %s_quot: got %h required %h", name, M_div_quot, e.q);
        end
        n_checks++;
        if (M_div_rem !== e.r) begin
            n_fail++;
            $display("FAIL %s_rem: got %h required %h", name, M_div_rem, e.r);
        end
        last_q = e.q;
        last_r = e.r;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (M_div_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", M_div_busy); end
        n_checks++;
        if (M_div_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", M_div_done); end
        n_checks++;
        if (M_div_quot !== '0) begin n_fail++; $display("FAIL reset_quot: got %h required 0", M_div_quot); end
        n_checks++;
        if (M_div_rem !== '0) begin n_fail++; $display("FAIL reset_rem: got %h required 0", M_div_rem); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_unsigned();
        int t0;
        @(posedge clk); #1;
        start_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, t0);
        wait_done(t0, "unsigned_100_7");
        @(negedge clk);
        n_checks++;
        if (M_div_busy !== 1'b0 || M_div_done !== 1'b0) begin
            n_fail++;
            $display("FAIL unsigned_after_done: busy=%b done=%b required 0 0 in cycle %0d", M_div_busy, M_div_done, LAT + 1);
        end
    endtask

    task automatic test_signed();
        int t0;
        @(posedge clk); #1;
        start_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, t0);
        wait_done(t0, "signed_m7_2");
        @(posedge clk); #1;
        start_op(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, t0);
        wait_done(t0, "unsigned_fff9_2");
    endtask

    task automatic test_div_zero();
        int t0;
        for (int s = 0; s < 2; s++) begin
            @(posedge clk); #1;
            start_op(32'h0000_1234, 32'd0, 1'(s), DIV_ZERO_QUOT, 32'h0000_1234, t0);
            wait_done(t0, s ? "divzero_signed" : "divzero_unsigned");
        end
    endtask

    task automatic test_overflow();
        int t0;
        @(posedge clk); #1;
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, DIV_OVF_QUOT, 32'd0, t0);
        wait_done(t0, "signed_overflow");
        @(posedge clk); #1;
        start_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, t0);
        wait_done(t0, "unsigned_max_1");
    endtask

    task automatic test_back_to_back();
        int           t0;
        logic [W-1:0] a, b, eq, er;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom >> (i * 5);
            b = b | 32'd1;
            model(a, b, 1'(i), eq, er);
            @(posedge clk); #1;
            start_op(a, b, 1'(i), eq, er, t0);
            wait_done(t0, "back_to_back");
        end
    endtask

    task automatic test_kill();
        int t0, t1;
        @(posedge clk); #1;
        start_op(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, t0);
        repeat (9) @(posedge clk);
        #1;
        E_div_kill = 1'b1;
        void'(sb.pop_back());
        @(posedge clk); #1;
        E_div_kill = 1'b0;
        n_checks++;
        if (M_div_quot !== last_q || M_div_rem !== last_r) begin
            n_fail++;
            $display("FAIL kill_outputs_held: quot=%h rem=%h required %h %h", M_div_quot, M_div_rem, last_q, last_r);
        end
        start_op(32'd20, 32'd3, 1'b0, 32'd6, 32'd2, t1);
        n_checks++;
        if ((t1 - t0) !== 11) begin
            n_fail++;
            $display("FAIL kill_restart_cycle: restart in cycle %0d required 11", t1 - t0);
        end
        repeat (3) @(posedge clk);
        #1;
        E_src1       = 32'd50;
        E_src2       = 32'd5;
        E_div_signed = 1'b0;
        E_div_start  = 1'b1;
        @(posedge clk); #1;
        E_div_start = 1'b0;
        wait_done(t1, "kill_restart_20_3");
        @(negedge clk);
        n_checks++;
        if (M_div_busy !== 1'b0 || M_div_done !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_ignored: busy=%b done=%b required 0 0", M_div_busy, M_div_done);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        @(posedge clk); #1;
        start_op(32'd1000, 32'd7, 1'b0, 32'd142, 32'd6, t0);
        repeat (14) @(posedge clk);
        #1;
        reset_n = 1'b0;
        void'(sb.pop_back());
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (M_div_busy !== 1'b0 || M_div_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_flags: busy=%b done=%b required 0 0", M_div_busy, M_div_done);
        end
        n_checks++;
        if (M_div_quot !== '0 || M_div_rem !== '0) begin
            n_fail++;
            $display("FAIL midreset_results: quot=%h rem=%h required 0 0", M_div_quot, M_div_rem);
        end
        last_q = '0;
        last_r = '0;
    endtask

    task automatic test_kill_start_idle();
        bit seen = 1'b0;
        @(posedge clk); #1;
        E_src1       = 32'd77;
        E_src2       = 32'd7;
        E_div_signed = 1'b0;
        E_div_start  = 1'b1;
        E_div_kill   = 1'b1;
        @(posedge clk); #1;
        E_div_start = 1'b0;
        E_div_kill  = 1'b0;
        @(negedge clk);
        n_checks++;
        if (M_div_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_beats_start_busy: got %b required 0", M_div_busy);
        end
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            if (M_div_done === 1'b1 || M_div_busy === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL kill_beats_start_activity: busy or done seen, required none");
        end
        n_checks++;
        if (M_div_quot !== last_q || M_div_rem !== last_r) begin
            n_fail++;
            $display("FAIL kill_beats_start_outputs: quot=%h rem=%h required %h %h", M_div_quot, M_div_rem, last_q, last_r);
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        E_src1       = '0;
        E_src2       = '0;
        E_div_start  = 1'b0;
        E_div_signed = 1'b0;
        E_div_kill   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_kill();
        test_reset_mid();
        test_kill_start_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
